ps2_port: RTL

- PS/2 device-to-host receiver that sits directly upstream of the keyboard matrix translator.
- Turns raw clkps2/dataps2 pins into validated scancode events: one byte plus release/extended qualifiers, announced by a single-cycle strobe.
- Runs on the 6.5 MHz video clock.
- Frames with errors are dropped and reported. The translator only ever sees clean events.

---
 rtl/ps2_port.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ps2_port.sv
// PS/2 device-to-host receiver: synchronises and filters the raw pins, frames
// 11-bit packets and emits validated scancode events with release/extended qualifiers.
module ps2_port #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 6500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended,
  output logic       kb_interrupt,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

  state_t            state, state_nx;
  logic [1:0]        clk_sync, dat_sync;
  logic [FILTER-1:0] filt_sr;
  logic              filt_clk;
  logic              ps2_edge;
  logic [3:0]        bitcnt;
  logic              start_bit;
  logic [9:0]        frame_sr;   // {stop, parity, data[7:0]} once complete
  logic [TW-1:0]     to_cnt;
  logic              timeout_hit;
  logic              frame_valid;
  logic              pre_rel, pre_ext;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make stage ordering matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], clkps2};
      dat_sync <= {dat_sync[0], dataps2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      filt_sr <= {filt_sr[FILTER-2:0], clk_sync[1]};
      if (filt_sr == '0)
        filt_clk <= 1'b0;
      else if (filt_sr == '1)
        filt_clk <= 1'b1;
    end
  end

  // The edge cycle is the one in which the filtered clock is about to fall.
  assign ps2_edge    = filt_clk && (filt_sr == '0);
  assign timeout_hit = (state == RECEIVE) && !ps2_edge && (to_cnt == TW'(TIMEOUT - 1));
  assign frame_valid = !start_bit && frame_sr[9] && (^frame_sr[8:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ps2_edge) state_nx = RECEIVE;
      RECEIVE: begin
        if (timeout_hit)                       state_nx = IDLE;
        else if (ps2_edge && bitcnt == 4'd10)  state_nx = CHECK;
      end
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt    <= '0;
      start_bit <= 1'b1;
      frame_sr  <= '0;
      to_cnt    <= '0;
    end else begin
      if (state != RECEIVE || ps2_edge) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      if (ps2_edge) begin
        if (state == IDLE) begin
          start_bit <= dat_sync[1];
          bitcnt    <= 4'd1;
        end else if (state == RECEIVE) begin
          frame_sr <= {dat_sync[1], frame_sr[9:1]};
          bitcnt   <= bitcnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scancode     <= '0;
      released     <= 1'b0;
      extended     <= 1'b0;
      kb_interrupt <= 1'b0;
      frame_error  <= 1'b0;
      pre_rel      <= 1'b0;
      pre_ext      <= 1'b0;
    end else begin
      kb_interrupt <= 1'b0;
      frame_error  <= 1'b0;
      if (timeout_hit) begin
        frame_error <= 1'b1;
        pre_rel     <= 1'b0;
        pre_ext     <= 1'b0;
      end else if (state == CHECK) begin
        if (!frame_valid) begin
          frame_error <= 1'b1;
          pre_rel     <= 1'b0;
          pre_ext     <= 1'b0;
        end else if (frame_sr[7:0] == 8'hE0) begin
          pre_ext <= 1'b1;
        end else if (frame_sr[7:0] == 8'hF0) begin
          pre_rel <= 1'b1;
        end else begin
          // Prefix flags are consumed by this event and cleared alongside it.
          scancode     <= frame_sr[7:0];
          released     <= pre_rel;
          extended     <= pre_ext;
          kb_interrupt <= 1'b1;
          pre_rel      <= 1'b0;
          pre_ext      <= 1'b0;
        end
      end
    end
  end

endmodule
